// File: rtl/adc_trig_decim.sv
// adc_trig_decim: armed level-crossing trigger and 2^N box-car decimator
// producing packed dual-channel samples for the sample-memory controller.
module adc_trig_decim #(
    parameter int DW    = 12,
    parameter int LEN_W = 13,
    parameter int DEC_W = 3
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [DW-1:0]    ad_data_ch0_i,
    input  logic [DW-1:0]    ad_data_ch1_i,
    input  logic             arm_i,
    input  logic             abort_i,
    input  logic [1:0]       trig_mode_i,
    input  logic             trig_ch_i,
    input  logic [DW-1:0]    trig_level_i,
    input  logic [DEC_W-1:0] dec_log2_i,
    input  logic [LEN_W-1:0] len_i,
    output logic [31:0]      sample_o,
    output logic             sample_vld_o,
    output logic             trig_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [LEN_W:0]   sample_cnt_o
);
    localparam int CW  = (1 << DEC_W) - 1;
    localparam int AW  = DW + CW;
    localparam int PAD = 16 - DW;
    localparam logic [DEC_W-1:0] CWV = DEC_W'(CW);

    typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_e;

    state_e state_q, state_d;

    logic [1:0]       mode_q, mode_d;
    logic             ch_q, ch_d;
    logic [DW-1:0]    level_q, level_d;
    logic [DEC_W-1:0] dec_q, dec_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [DW-1:0]    prev_q, prev_d;
    logic             first_q, first_d;
    logic [AW-1:0]    acc0_q, acc0_d;
    logic [AW-1:0]    acc1_q, acc1_d;
    logic [CW-1:0]    in_cnt_q, in_cnt_d;
    logic [31:0]      sample_q, sample_d;
    logic             vld_q, vld_d;
    logic             trig_q, trig_d;
    logic [LEN_W:0]   cnt_q, cnt_d;

    logic [DW-1:0]    cur;
    logic             trig_hit;
    logic             arm_ok;
    logic             last_out;
    logic [LEN_W:0]   len_eff;
    logic [CW-1:0]    last_cnt;
    logic [AW-1:0]    sum0, sum1, sh0, sh1;

    assign cur      = ch_q ? ad_data_ch1_i : ad_data_ch0_i;
    assign arm_ok   = arm_i && (state_q == IDLE || state_q == DONE);
    assign len_eff  = {(len_q == '0), len_q};
    assign last_out = vld_q && (cnt_q == len_eff);
    assign last_cnt = {CW{1'b1}} >> (CWV - dec_q);
    assign sum0     = acc0_q + AW'(ad_data_ch0_i);
    assign sum1     = acc1_q + AW'(ad_data_ch1_i);
    assign sh0      = sum0 >> dec_q;
    assign sh1      = sum1 >> dec_q;

    // prev is only meaningful from the second armed cycle on
    always_comb begin
        case (mode_q)
            2'd1:    trig_hit = !first_q && (prev_q < level_q)
                                && (cur >= level_q);
            2'd2:    trig_hit = !first_q && (prev_q >= level_q)
                                && (cur < level_q);
            default: trig_hit = 1'b1;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: if (arm_i)    state_d = ARMED;
                ARMED:      if (trig_hit) state_d = RUN;
                RUN:        if (last_out) state_d = DONE;
                default:                  state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        mode_d   = mode_q;
        ch_d     = ch_q;
        level_d  = level_q;
        dec_d    = dec_q;
        len_d    = len_q;
        prev_d   = cur;
        first_d  = 1'b0;
        acc0_d   = acc0_q;
        acc1_d   = acc1_q;
        in_cnt_d = in_cnt_q;
        sample_d = sample_q;
        vld_d    = 1'b0;
        trig_d   = 1'b0;
        cnt_d    = cnt_q;
        if (abort_i) begin
            acc0_d   = '0;
            acc1_d   = '0;
            in_cnt_d = '0;
        end else if (arm_ok) begin
            mode_d   = trig_mode_i;
            ch_d     = trig_ch_i;
            level_d  = trig_level_i;
            dec_d    = dec_log2_i;
            len_d    = len_i;
            first_d  = 1'b1;
            acc0_d   = '0;
            acc1_d   = '0;
            in_cnt_d = '0;
            cnt_d    = '0;
        end else if (state_q == ARMED && trig_hit) begin
            trig_d = 1'b1;
        end else if (state_q == RUN && !last_out) begin
            // closing input of a window: emit and restart with no gap
            if (in_cnt_q == last_cnt) begin
                sample_d = {{PAD{1'b0}}, sh1[DW-1:0],
                            {PAD{1'b0}}, sh0[DW-1:0]};
                vld_d    = 1'b1;
                cnt_d    = cnt_q + (LEN_W+1)'(1);
                acc0_d   = '0;
                acc1_d   = '0;
                in_cnt_d = '0;
            end else begin
                acc0_d   = sum0;
                acc1_d   = sum1;
                in_cnt_d = in_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            mode_q   <= '0;
            ch_q     <= 1'b0;
            level_q  <= '0;
            dec_q    <= '0;
            len_q    <= '0;
            prev_q   <= '0;
            first_q  <= 1'b0;
            acc0_q   <= '0;
            acc1_q   <= '0;
            in_cnt_q <= '0;
            sample_q <= '0;
            vld_q    <= 1'b0;
            trig_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            mode_q   <= mode_d;
            ch_q     <= ch_d;
            level_q  <= level_d;
            dec_q    <= dec_d;
            len_q    <= len_d;
            prev_q   <= prev_d;
            first_q  <= first_d;
            acc0_q   <= acc0_d;
            acc1_q   <= acc1_d;
            in_cnt_q <= in_cnt_d;
            sample_q <= sample_d;
            vld_q    <= vld_d;
            trig_q   <= trig_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        busy_o = (state_q == ARMED) || (state_q == RUN);
        done_o = (state_q == DONE);
    end

    assign sample_o     = sample_q;
    assign sample_vld_o = vld_q;
    assign trig_o       = trig_q;
    assign sample_cnt_o = cnt_q;

endmodule

// File: tb/tb_adc_trig_decim.sv
// Scoreboard bench for adc_trig_decim: directed captures with
// hand-computed packed samples checked by an independent monitor.
module tb_adc_trig_decim;
    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [11:0] ch0, ch1;
    logic        arm_i, abort_i;
    logic [1:0]  trig_mode;
    logic        trig_ch;
    logic [11:0] trig_level;
    logic [2:0]  dec_log2;
    logic [12:0] len;
    logic [31:0] sample_o;
    logic        sample_vld_o, trig_o, busy_o, done_o;
    logic [13:0] sample_cnt_o;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    adc_trig_decim dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .ad_data_ch0_i (ch0),
        .ad_data_ch1_i (ch1),
        .arm_i         (arm_i),
        .abort_i       (abort_i),
        .trig_mode_i   (trig_mode),
        .trig_ch_i     (trig_ch),
        .trig_level_i  (trig_level),
        .dec_log2_i    (dec_log2),
        .len_i         (len),
        .sample_o      (sample_o),
        .sample_vld_o  (sample_vld_o),
        .trig_o        (trig_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .sample_cnt_o  (sample_cnt_o)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (sample_vld_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got %h expected none",
                         sample_o);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (sample_o !== e) begin
                    errors++;
                    $display("FAIL sample: got %h expected %h", sample_o, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic arm_cfg(logic [1:0] m, logic c, logic [11:0] lv,
                           logic [2:0] n, logic [12:0] l);
        trig_mode  = m;
        trig_ch    = c;
        trig_level = lv;
        dec_log2   = n;
        len        = l;
        arm_i      = 1'b1;
        tick();
        arm_i      = 1'b0;
    endtask

    task automatic run_until_done(int max);
        int n = 0;
        while (!done_o && n < max) begin
            tick();
            n++;
        end
        chk("done_reached", {31'b0, done_o}, 32'd1);
    endtask

    task automatic drained(string nm);
        chk(nm, exp_q.size(), 32'd0);
    endtask

    initial begin
        int ntrig;
        int vs[$];
        sys_rst = 1'b1; ch0 = '0; ch1 = '0; arm_i = 1'b0; abort_i = 1'b0;
        trig_mode = '0; trig_ch = 1'b0; trig_level = '0;
        dec_log2 = '0; len = '0;
        repeat (3) tick();
        chk("rst_sample", sample_o, 32'h0);
        chk("rst_flags", {27'b0, sample_vld_o, trig_o, busy_o, done_o, 1'b0},
            32'h0);
        chk("rst_cnt", {18'b0, sample_cnt_o}, 32'h0);
        sys_rst = 1'b0;
        tick();

        // immediate, N=0, len=4, ramp on ch0
        for (int i = 1; i <= 4; i++) exp_q.push_back(32'h0ABC_0000 + i);
        ch1 = 12'hABC; ch0 = 12'hFFF;
        arm_cfg(2'd0, 1'b0, 12'h000, 3'd0, 13'd4);
        for (int i = 1; i <= 7; i++) begin
            ch0 = 12'(i - 1);
            if (i == 1) chk("t1_busy_armed", {31'b0, busy_o}, 32'd1);
            if (i == 2) chk("t1_trig", {31'b0, trig_o}, 32'd1);
            if (i >= 3 && i <= 6)
                chk("t1_vld", {31'b0, sample_vld_o}, 32'd1);
            if (i == 7) begin
                chk("t1_done", {31'b0, done_o}, 32'd1);
                chk("t1_busy", {31'b0, busy_o}, 32'd0);
                chk("t1_cnt", {18'b0, sample_cnt_o}, 32'd4);
            end
            tick();
        end
        drained("t1_drained");

        // rising edge on ch0 at 0x800
        exp_q.push_back(32'h0000_0801);
        exp_q.push_back(32'h0000_0802);
        ch1 = 12'h000; ch0 = 12'h7FC;
        arm_cfg(2'd1, 1'b0, 12'h800, 3'd0, 13'd2);
        for (int i = 1; i <= 8; i++) begin
            ch0 = 12'h7FC + 12'(i);
            chk("t2_trig", {31'b0, trig_o}, {31'b0, i == 5});
            if (i == 8) chk("t2_done", {31'b0, done_o}, 32'd1);
            tick();
        end
        drained("t2_drained");

        // falling edge on ch1 at 0x100, N=2
        repeat (3) exp_q.push_back(32'h0050_0123);
        ch0 = 12'h123; ch1 = 12'h200;
        arm_cfg(2'd2, 1'b1, 12'h100, 3'd2, 13'd3);
        ntrig = 0;
        for (int i = 1; i <= 18; i++) begin
            ch1 = (i >= 4) ? 12'h050 : 12'h200;
            if (trig_o) ntrig++;
            if (sample_vld_o) vs.push_back(i);
            if (i == 18) chk("t3_done", {31'b0, done_o}, 32'd1);
            tick();
        end
        chk("t3_ntrig", ntrig, 32'd1);
        chk("t3_nvld", vs.size(), 32'd3);
        if (vs.size() == 3) begin
            chk("t3_first_vld", vs[0], 32'd9);
            chk("t3_gap1", vs[1] - vs[0], 32'd4);
            chk("t3_gap2", vs[2] - vs[1], 32'd4);
        end
        drained("t3_drained");

        // N=1 truncation of 1+2
        repeat (2) exp_q.push_back(32'h0000_0001);
        ch1 = 12'h000; ch0 = 12'h001;
        arm_cfg(2'd0, 1'b0, 12'h000, 3'd1, 13'd2);
        for (int i = 1; i <= 7; i++) begin
            ch0 = (i % 2 == 0) ? 12'h001 : 12'h002;
            if (i == 7) chk("t4_done", {31'b0, done_o}, 32'd1);
            tick();
        end
        drained("t4_drained");

        // abort after 2 of 5
        repeat (2) exp_q.push_back(32'h00AA_0055);
        ch0 = 12'h055; ch1 = 12'h0AA;
        arm_cfg(2'd0, 1'b0, 12'h000, 3'd0, 13'd5);
        repeat (3) tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("t5_busy", {31'b0, busy_o}, 32'd0);
        chk("t5_done", {31'b0, done_o}, 32'd0);
        chk("t5_cnt", {18'b0, sample_cnt_o}, 32'd2);
        abort_i = 1'b1; arm_i = 1'b1;
        tick();
        abort_i = 1'b0; arm_i = 1'b0;
        chk("t5_abort_wins", {31'b0, busy_o}, 32'd0);
        repeat (4) tick();
        drained("t5_drained");
        exp_q.push_back(32'h00AA_0055);
        arm_cfg(2'd0, 1'b0, 12'h000, 3'd0, 13'd1);
        chk("t5_rearm_cnt", {18'b0, sample_cnt_o}, 32'd0);
        run_until_done(20);
        chk("t5_rearm_final", {18'b0, sample_cnt_o}, 32'd1);
        drained("t5_rearm_drained");

        // len=0 -> 8192 outputs, arm ignored while running
        repeat (8192) exp_q.push_back(32'h01E1_03C3);
        ch0 = 12'h3C3; ch1 = 12'h1E1;
        arm_cfg(2'd0, 1'b0, 12'h000, 3'd0, 13'd0);
        repeat (100) tick();
        len = 13'd1; trig_mode = 2'd1; arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
        chk("t6_busy_after_arm", {31'b0, busy_o}, 32'd1);
        run_until_done(8300);
        chk("t6_cnt", {18'b0, sample_cnt_o}, 32'd8192);
        drained("t6_drained");

        // reset in the middle of a run
        repeat (3) exp_q.push_back(32'h01E1_03C3);
        arm_cfg(2'd0, 1'b0, 12'h000, 3'd0, 13'd0);
        repeat (4) tick();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        chk("t7_sample", sample_o, 32'h0);
        chk("t7_flags", {27'b0, sample_vld_o, trig_o, busy_o, done_o, 1'b0},
            32'h0);
        chk("t7_cnt", {18'b0, sample_cnt_o}, 32'h0);
        repeat (3) tick();
        drained("t7_drained");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/adc_trig_decim.md
Name: adc_trig_decim

Overview:
Acquisition front-end between the dual-channel ADC capture outputs and the ADC sample-memory controller.
- Waits for a software arm, then for a level-crossing trigger on a selected channel (or triggers immediately).
- Box-car averages 2^N raw samples per channel and emits a fixed number of packed 32-bit averaged samples with a valid strobe.
- The memory controller writes those samples to data RAM; status and config come from CSR fields.

Parameters:
DW, 12, raw ADC sample width per channel (unsigned, offset binary)
LEN_W, 13, width of capture-length field; max capture = 2^LEN_W samples
DEC_W, 3, width of decimation exponent; max averaging = 2^(2^DEC_W - 1) = 128

Ports:
sys_clk  in  1  system clock; all logic on rising edge
sys_rst  in  1  synchronous active-high reset
ad_data_ch0_i  in  DW  ADC channel 0 sample, new value every sys_clk
ad_data_ch1_i  in  DW  ADC channel 1 sample, new value every sys_clk
arm_i  in  1  single-cycle arm pulse (CSR)
abort_i  in  1  single-cycle abort pulse (CSR)
trig_mode_i  in  2  0=immediate, 1=rising edge, 2=falling edge, 3=reserved (behaves as immediate)
trig_ch_i  in  1  trigger source channel select
trig_level_i  in  DW  trigger threshold
dec_log2_i  in  DEC_W  averaging exponent N
len_i  in  LEN_W  output sample count; 0 means 2^LEN_W
sample_o  out  32  {4'b0, ch1_avg, 4'b0, ch0_avg} (adc_sample_t layout)
sample_vld_o  out  1  one-cycle strobe, sample_o valid
trig_o  out  1  one-cycle pulse on trigger acceptance
busy_o  out  1  high in ARMED or RUN
done_o  out  1  high in DONE
sample_cnt_o  out  LEN_W+1  outputs emitted in current capture

Behaviour:
- Reset values: state IDLE; sample_o=0; sample_vld_o=0; trig_o=0; busy_o=0; done_o=0; sample_cnt_o=0; accumulators=0; prev-sample register=0.
- Config latch: all config inputs are latched on the cycle arm_i is accepted. Changes after that have no effect until the next arm.
- Prev register: holds the previous cycle's sample of the latched trigger channel and updates every cycle.

State machine: IDLE, ARMED, RUN, DONE.
- IDLE or DONE + arm_i → ARMED next cycle. Entering ARMED clears done_o, sample_cnt_o and the accumulators.
- arm_i in ARMED or RUN is ignored.
- ARMED, immediate mode → RUN on the next cycle unconditionally.
- ARMED, rising mode: trigger when prev < level && cur >= level.
- ARMED, falling mode: trigger when prev >= level && cur < level.
- The first ARMED cycle never triggers (prev not yet valid).
- Trigger detected in cycle t → state RUN and trig_o=1 at t+1.
- RUN: the first RUN cycle's input is the first accumulated sample; the trigger sample is excluded.
  - Each cycle, both channels are added into (DW+7)-bit accumulators.
  - After 2^N inputs, the next cycle shows sample_o = acc >> N (truncating) and sample_vld_o=1.
  - The accumulators restart with that cycle's input, giving no gaps.
  - N=0: output at cycle k+1 equals input at cycle k.
- sample_cnt_o increments with each sample_vld_o. The cycle after the output that makes sample_cnt_o = len (len 0 → 2^LEN_W): state DONE, done_o=1, no further strobes.
- sample_o holds its last value between strobes.
- abort_i in any state → IDLE next cycle. done_o=0, busy_o=0, the pending partial average is discarded, sample_cnt_o is held.
- abort_i and arm_i in the same cycle: abort wins.
- sys_rst mid-capture: all outputs return to reset values next cycle; no strobe is issued.
- Unsigned arithmetic throughout; no overflow possible: 12+7 bits ≥ 4095·128.

Test Plan:
- Immediate, N=0, len=4, ch0 ramp 0x000,0x001,…; ch1=0xABC → arm at t0: RUN at t0+1; 4 strobes at t0+3..t0+6 with ch0 = 0x001..0x004 and ch1 = 0xABC (sample_o 0x0ABC_0001…); done_o=1 at t0+7; busy_o low.
- Rising trigger, ch0, level 0x800, ch0 ramp 0x7FC upward by 1 per cycle, N=0, len=2 → trig_o one cycle after ch0 = 0x800 is presented; strobes carry 0x801, 0x802.
- Falling trigger, ch1, level 0x100, N=2, len=3, constant ch0=0x123, ch1 stepping 0x200→0x050 → single trig_o; 3 strobes 4 cycles apart; each sample_o=0x0050_0123.
- Averaging truncation: N=1, ch0 alternating 0x001/0x002, immediate, len=2 → ch0_avg = 0x001 (3>>1) on both strobes.
- Abort after 2 of len=5 strobes (N=0) → IDLE next cycle; no further strobes; done_o=0; sample_cnt_o=2; re-arm clears cnt and a new capture completes.
- len=0, N=0, immediate → exactly 8192 strobes, sample_cnt_o=8192, then done_o=1; arm_i during RUN ignored; sys_rst mid-run clears all outputs.
